// File: rtl/dmem_bus_bridge.sv
// ----------------------------------------------------------------------------
// dmem_bus_bridge
//
// Multi-cycle bridge between the CPU's byte-lane data-memory port and a
// valid/ready data bus. Each CPU load or store becomes exactly one bus
// request/response transaction. The pipeline is held with `stall` until
// that transaction completes. The raw 32-bit read word is returned
// unmodified; lane extraction and sign extension are done upstream.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles to wait for a response before aborting (1..255)
//   ERR_DATA        word returned on rdata after a timeout
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req             memory-stage load/store request
//   addr[9:0]       word address (byte address [11:2])
//   we[3:0]         byte write enables, 4'b0000 = read
//   wdata[31:0]     lane-replicated store data
//   rdata[31:0]     read word, valid in the DONE cycle
//   stall           pipeline freeze (combinational from state and req)
//   err             one-cycle pulse in the DONE cycle of a timed-out access
//   bus_valid       bus request valid (registered)
//   bus_ready       bus accepts the request
//   bus_addr/we/wdata  latched request fields (registered)
//   bus_rsp_valid   bus response or write acknowledge
//   bus_rdata[31:0] bus response data
// ----------------------------------------------------------------------------
module dmem_bus_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [9:0]  addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [9:0]  bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state;
    logic [7:0] cnt;

    // NOTE: all state below is sequential and uses non-blocking assignments
    // so every register sees pre-edge values of the others; blocking here
    // would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            bus_valid <= 1'b0;
            bus_addr  <= 10'd0;
            bus_we    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Stray responses are ignored here by construction.
                    if (req) begin
                        bus_addr  <= addr;
                        bus_we    <= we;
                        bus_wdata <= wdata;
                        bus_valid <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    // Request fields stay frozen until the bus accepts.
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    // Saturating counter: it never wraps back under the limit.
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (bus_rsp_valid) begin
                        rdata <= bus_rdata;
                        state <= DONE;
                    end else if (cnt == TIMEOUT_LIMIT) begin
                        rdata <= ERR_DATA;
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // req is deliberately not sampled: the pipeline advances
                    // one instruction this cycle and IDLE picks up the next.
                    err   <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: stall gets a value on every path so no latch is inferred.
    always_comb begin
        stall = 1'b1;
        case (state)
            IDLE:    stall = req;
            DONE:    stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// ----------------------------------------------------------------------------
// tb_dmem_bus_bridge
//
// Directed bench for dmem_bus_bridge with TIMEOUT_CYCLES = 4. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle numbers in comments count from the cycle in which req is raised.
// ----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [9:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        bus_valid;
    logic        bus_ready;
    logic [9:0]  bus_addr;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int acc_base;

    dmem_bus_bridge #(
        .TIMEOUT_CYCLES (4),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .addr          (addr),
        .we            (we),
        .wdata         (wdata),
        .rdata         (rdata),
        .stall         (stall),
        .err           (err),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    // Count bus handshakes; inputs are stable around the rising edge.
    always @(posedge clk) begin
        if (bus_valid && bus_ready) accepts <= accepts + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to the start of the next cycle (just after the rising edge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req           = 1'b0;
        addr          = 10'd0;
        we            = 4'd0;
        wdata         = 32'd0;
        bus_ready     = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'd0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        req   = 1'b1;
        #2;
        // stall follows req even in reset
        check("rst_stall_req1", stall, 1'b1);
        req = 1'b0;
        #1;
        check("rst_stall_req0", stall, 1'b0);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", err, 1'b0);
        check("rst_bus_addr", bus_addr, 10'd0);
        check("rst_bus_we", bus_we, 4'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ---------------- read, zero wait ----------------
        acc_base = accepts;
        req = 1'b1; we = 4'd0; addr = 10'h004;           // cycle 0
        sample();
        check("rd_c0_stall", stall, 1'b1);
        check("rd_c0_valid", bus_valid, 1'b0);
        next_cycle(); bus_ready = 1'b1;                 // cycle 1
        sample();
        check("rd_c1_stall", stall, 1'b1);
        check("rd_c1_valid", bus_valid, 1'b1);
        check("rd_c1_addr", bus_addr, 10'h004);
        check("rd_c1_we", bus_we, 4'd0);
        next_cycle(); bus_ready = 1'b0;                 // cycle 2
        bus_rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        sample();
        check("rd_c2_stall", stall, 1'b1);
        check("rd_c2_valid", bus_valid, 1'b0);
        next_cycle(); bus_rsp_valid = 1'b0; req = 1'b0; // cycle 3 DONE
        sample();
        check("rd_c3_stall", stall, 1'b0);
        check("rd_c3_rdata", rdata, 32'h1234_5678);
        check("rd_c3_err", err, 1'b0);
        next_cycle();                                    // cycle 4 IDLE
        sample();
        check("rd_c4_stall", stall, 1'b0);
        check("rd_c4_valid", bus_valid, 1'b0);
        check("rd_accepts", accepts - acc_base, 1);

        // ---------------- write with backpressure ----------------
        acc_base = accepts;
        next_cycle();
        req = 1'b1; we = 4'b0100; wdata = 32'hABAB_ABAB; addr = 10'h155; // cycle 0
        sample();
        check("wr_c0_stall", stall, 1'b1);
        for (int i = 1; i <= 4; i++) begin               // cycles 1..4 in REQ
            next_cycle();
            bus_ready = (i == 4);
            sample();
            check("wr_bp_valid", bus_valid, 1'b1);
            check("wr_bp_addr", bus_addr, 10'h155);
            check("wr_bp_we", bus_we, 4'b0100);
            check("wr_bp_wdata", bus_wdata, 32'hABAB_ABAB);
            check("wr_bp_stall", stall, 1'b1);
        end
        next_cycle(); bus_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'h0; // cycle 5
        sample();
        check("wr_c5_valid", bus_valid, 1'b0);
        check("wr_c5_stall", stall, 1'b1);
        next_cycle(); bus_rsp_valid = 1'b0; req = 1'b0;  // cycle 6 DONE
        sample();
        check("wr_c6_stall", stall, 1'b0);
        check("wr_c6_err", err, 1'b0);
        next_cycle();
        sample();
        check("wr_accepts", accepts - acc_base, 1);

        // ---------------- back-to-back ----------------
        acc_base = accepts;
        next_cycle();
        req = 1'b1; we = 4'd0; addr = 10'h010;           // cycle 0
        next_cycle(); bus_ready = 1'b1;                  // cycle 1
        sample();
        check("b2b_1_addr", bus_addr, 10'h010);
        next_cycle(); bus_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'hAAAA_0001; // cycle 2
        next_cycle(); bus_rsp_valid = 1'b0; addr = 10'h011;       // cycle 3 DONE, req still 1
        sample();
        check("b2b_done1_stall", stall, 1'b0);
        check("b2b_done1_rdata", rdata, 32'hAAAA_0001);
        next_cycle();                                    // cycle 4 IDLE samples req
        sample();
        check("b2b_idle_stall", stall, 1'b1);
        next_cycle(); bus_ready = 1'b1;                  // cycle 5 REQ
        sample();
        check("b2b_2_valid", bus_valid, 1'b1);
        check("b2b_2_addr", bus_addr, 10'h011);
        check("b2b_2_stall", stall, 1'b1);
        next_cycle(); bus_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'hBBBB_0002; // cycle 6
        next_cycle(); bus_rsp_valid = 1'b0; req = 1'b0;  // cycle 7 DONE
        sample();
        check("b2b_done2_stall", stall, 1'b0);
        check("b2b_done2_rdata", rdata, 32'hBBBB_0002);
        next_cycle();
        sample();
        check("b2b_end_stall", stall, 1'b0);
        check("b2b_accepts", accepts - acc_base, 2);

        // ---------------- timeout (limit 4) ----------------
        next_cycle();
        req = 1'b1; we = 4'd0; addr = 10'h007;           // cycle 0
        next_cycle(); bus_ready = 1'b1;                  // cycle 1
        next_cycle(); bus_ready = 1'b0;                  // cycle 2: WAIT_RSP entry
        for (int i = 2; i <= 6; i++) begin               // five WAIT_RSP cycles
            sample();
            check("to_wait_stall", stall, 1'b1);
            check("to_wait_err", err, 1'b0);
            next_cycle();
        end
        req = 1'b0;                                      // cycle 7 DONE
        sample();
        check("to_done_stall", stall, 1'b0);
        check("to_done_err", err, 1'b1);
        check("to_done_rdata", rdata, 32'hDEAD_BEEF);
        next_cycle();                                    // cycle 8 IDLE
        sample();
        check("to_idle_err", err, 1'b0);
        check("to_idle_stall", stall, 1'b0);

        // ---------------- stray response in IDLE ----------------
        next_cycle(); bus_rsp_valid = 1'b1; bus_rdata = 32'h5555_5555;
        next_cycle(); bus_rsp_valid = 1'b0;
        sample();
        check("stray_stall", stall, 1'b0);
        check("stray_valid", bus_valid, 1'b0);
        check("stray_rdata", rdata, 32'hDEAD_BEEF);
        check("stray_err", err, 1'b0);

        // ---------------- reset during WAIT_RSP ----------------
        next_cycle();
        req = 1'b1; we = 4'b1111; wdata = 32'hCAFE_F00D; addr = 10'h009; // cycle 0
        next_cycle(); bus_ready = 1'b1;                  // cycle 1
        next_cycle(); bus_ready = 1'b0;                  // cycle 2 WAIT_RSP
        rst_n = 1'b0;
        sample();
        check("mrst_stall_req", stall, 1'b1);
        check("mrst_valid", bus_valid, 1'b0);
        check("mrst_rdata", rdata, 32'd0);
        check("mrst_bus_addr", bus_addr, 10'd0);
        req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rdata = 32'h7777_7777; // late response
        sample();
        check("late_stall", stall, 1'b0);
        next_cycle(); bus_rsp_valid = 1'b0;
        sample();
        check("late_stall2", stall, 1'b0);
        check("late_valid", bus_valid, 1'b0);
        check("late_rdata", rdata, 32'd0);
        check("late_err", err, 1'b0);

        // ---------------- no access ----------------
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            sample();
            check("noacc_stall", stall, 1'b0);
            check("noacc_valid", bus_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

- Multi-cycle data-memory bridge between the CPU's byte-lane memory port and a valid/ready data bus.
- On the CPU side it takes the word address, write data and 4-bit write-enable produced by the load/store lane formatter.
- It converts each access into one bus request/response transaction and holds the pipeline with `stall` until that transaction completes.
- It returns the raw 32-bit read word to the formatter; lane extraction and sign extension stay upstream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles to wait in WAIT_RSP before aborting; range 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: value returned on `rdata` after a timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input 1: memory-stage instruction performs a load or store this cycle.
- `addr` input 10: word address (byte address [11:2]).
- `we` input 4: byte write enables; 4'b0000 means read.
- `wdata` input 32: lane-replicated store data.
- `rdata` output 32: read word; valid only in the DONE cycle.
- `stall` output 1: freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM).
- `err` output 1: one-cycle pulse in the DONE cycle of a timed-out access.
- `bus_valid` output 1: bus request valid.
- `bus_ready` input 1: bus accepts the request.
- `bus_addr` output 10: latched word address.
- `bus_we` output 4: latched write enables.
- `bus_wdata` output 32: latched write data.
- `bus_rsp_valid` input 1: response or write acknowledge.
- `bus_rdata` input 32: response data.

## Operation
FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - If `req` is high, latch `addr`, `we` and `wdata` into request registers and go to REQ.
  - `stall` = `req`, combinational, so the issuing cycle is already stalled.
- REQ:
  - `bus_valid` = 1 and `bus_*` driven from the latched registers; they stay stable while `bus_ready` is low.
  - On `bus_ready`, go to WAIT_RSP and clear the timeout counter.
  - `stall` = 1.
- WAIT_RSP:
  - `bus_valid` = 0. The counter increments every cycle.
  - On `bus_rsp_valid`, capture `bus_rdata` into `rdata` (write acks capture too; value is ignored upstream) and go to DONE.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`, load `ERR_DATA`, set the error flag and go to DONE.
  - `stall` = 1.
- DONE:
  - `stall` = 0, so the pipeline advances exactly one instruction.
  - `err` = error flag.
  - Always return to IDLE; `req` is not sampled in DONE.
- `bus_rsp_valid` seen in IDLE, REQ or DONE is ignored; stray responses do not change state.
- `bus_rsp_valid` in the same cycle as acceptance is not a valid response; the bus answers no earlier than the cycle after `bus_ready`.
- Counter is 8 bits and saturates; it never wraps.
- `we` is passed through unchanged, with no check for a legal lane pattern.
- Exactly one transaction is outstanding; there is no pipelining of requests.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - State IDLE.
  - `rdata` = 0, `err` = 0, `bus_valid` = 0.
  - `bus_addr` = 0, `bus_we` = 0, `bus_wdata` = 0, counter = 0.
  - `stall` = `req`, combinational, even while reset is asserted.
- Reset mid-transaction: the FSM returns to IDLE immediately. Any later `bus_rsp_valid` for the abandoned request is dropped as a stray.
- Minimum access (ready on cycle 1, response on cycle 2): `req` at cycle 0, DONE at cycle 3. That is 3 stall cycles, and `rdata` is valid in cycle 3.
- Each cycle of `bus_ready` low adds one stall cycle. Each cycle of response delay adds one.
- Timeout DONE occurs `TIMEOUT_CYCLES`+1 cycles after entering WAIT_RSP.
- `bus_*` outputs are registered (no combinational path from `req` to the bus). `stall` is combinational from state and `req` only.

## Test plan
- Read, zero wait: `req`=1, `we`=0, `addr`=10'h004; `bus_ready`=1 in cycle 1; `bus_rsp_valid`=1 with `bus_rdata`=32'h1234_5678 in cycle 2 -> `stall` high in cycles 0-2, low in cycle 3; `rdata`=32'h1234_5678 in cycle 3; `err`=0.
- Write with backpressure: `we`=4'b0100, `wdata`=32'hABABABAB; `bus_ready` low for 3 cycles -> `bus_valid`, `bus_addr`, `bus_we` and `bus_wdata` constant for 4 cycles; `stall` released only in DONE; exactly one request is accepted.
- Back-to-back: `req` held high across two instructions -> two separate bus transactions. `stall` drops for exactly one cycle between them, and the second is sampled in the IDLE cycle after DONE.
- Timeout: `TIMEOUT_CYCLES`=4, response never arrives -> DONE 5 cycles after WAIT_RSP entry; `rdata`=32'hDEAD_BEEF; `err` pulses for one cycle; the FSM then returns to IDLE.
- Stray and reset: `bus_rsp_valid` pulsed in IDLE -> no state change. `rst_n` low during WAIT_RSP -> IDLE, `bus_valid`=0, `rdata`=0; a late response after release is ignored.
- No access: `req`=0 for 20 cycles -> `stall`=0 and `bus_valid`=0 throughout.
